// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between IF fetch and the loader/debug port.
// Optional IMEM_BOOT_HOLD_EN holds fetch off until boot_done has been seen.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IMEM_BOOT_HOLD_EN
  input  logic              boot_done,
`endif
  input  logic              if_ce,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              if_stall_req,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       RUN_W   = $clog2(LD_BURST_MAX) + 1;
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(LD_BURST_MAX);

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_IF    = 2'd1,
    RSP_LD_RD = 2'd2,
    RSP_LD_WR = 2'd3
  } rsp_e;

  rsp_e             rsp_q, rsp_d;
  logic [RUN_W-1:0] ld_run_q, ld_run_d;
  logic             ld_sel, if_sel, fetch_ok;

`ifdef IMEM_BOOT_HOLD_EN
  logic boot_ok_q, boot_ok_d;

  // Sticky: once boot_done is seen, fetch stays eligible until reset.
  assign boot_ok_d = boot_ok_q | boot_done;
  assign fetch_ok  = boot_ok_q;

  always_ff @(posedge clk) begin
    if (rst) boot_ok_q <= 1'b0;
    else     boot_ok_q <= boot_ok_d;
  end
`else
  assign fetch_ok = 1'b1;
`endif

  // Grant, burst counter, next response and memory drive.
  always_comb begin
    ld_sel    = 1'b0;
    if_sel    = 1'b0;
    ld_run_d  = ld_run_q;
    rsp_d     = RSP_NONE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      ld_sel = ld_req && (!if_ce || (ld_run_q < RUN_MAX));
      if_sel = if_ce && !ld_sel && fetch_ok;

      // The run only counts loader wins over a waiting fetch.
      if (!if_ce || if_sel || !fetch_ok) begin
        ld_run_d = '0;
      end else if (ld_sel && (ld_run_q < RUN_MAX)) begin
        ld_run_d = ld_run_q + RUN_W'(1);
      end

      if (ld_sel) begin
        rsp_d     = ld_we ? RSP_LD_WR : RSP_LD_RD;
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr[ADDR_W+1:2];
        mem_wdata = ld_wdata;
      end else if (if_sel) begin
        rsp_d     = RSP_IF;
        mem_en    = 1'b1;
        mem_addr  = if_addr[ADDR_W+1:2];
        mem_wdata = ld_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q    <= RSP_NONE;
      ld_run_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      ld_run_q <= ld_run_d;
    end
  end

  assign ld_gnt       = ld_sel;
  assign if_stall_req = !rst && if_ce && !if_sel;

  // Read data lands one cycle after the grant; steer it by the stored response kind.
  always_comb begin
    if_valid = 1'b0;
    if_inst  = '0;
    ld_ack   = 1'b0;
    ld_rdata = '0;
    if (!rst) begin
      case (rsp_q)
        RSP_IF: begin
          if_valid = 1'b1;
          if_inst  = mem_rdata;
        end
        RSP_LD_RD: begin
          ld_ack   = 1'b1;
          ld_rdata = mem_rdata;
        end
        RSP_LD_WR: ld_ack = 1'b1;
        default: ;
      endcase
    end
  end

  // Byte-offset and upper address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a write-first synchronous memory model.
module tb_imem_port_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_IF   = 2'd1;
  localparam logic [1:0] K_RD   = 2'd2;
  localparam logic [1:0] K_WR   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              if_ce;
  logic [31:0]       if_addr;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;
  logic              if_stall_req;
  logic              ld_req;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0] mem_model [2048];
  logic [31:0] ref_mem   [2048];
  exp_t        sb [$];
  int          n_vec;
  int          n_err;

  imem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
`ifdef IMEM_BOOT_HOLD_EN
    .boot_done    (1'b1),
`endif
    .if_ce        (if_ce),
    .if_addr      (if_addr),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .if_stall_req (if_stall_req),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_ack       (ld_ack),
    .ld_rdata     (ld_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous-read memory.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_model[mem_addr] <= mem_wdata;
        mem_rdata           <= mem_wdata;
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check response of the previous grant and this cycle's grant, then predict.
  task automatic step(input logic exp_if, input logic exp_ld);
    exp_t        e;
    logic [31:0] sel_addr;
    logic [10:0] wa;
    @(negedge clk);
    if (sb.size() == 0) e = '0;
    else                e = sb.pop_front();
    if (rst) e = '0;
    chk("if_valid", 32'(if_valid), 32'(e.kind == K_IF));
    chk("if_inst",  if_inst,       (e.kind == K_IF) ? e.data : 32'h0);
    chk("ld_ack",   32'(ld_ack),   32'((e.kind == K_RD) || (e.kind == K_WR)));
    chk("ld_rdata", ld_rdata,      (e.kind == K_RD) ? e.data : 32'h0);
    chk("if_stall_req", 32'(if_stall_req), 32'(if_ce && !exp_if && !rst));
    chk("ld_gnt",   32'(ld_gnt),   32'(exp_ld));
    chk("mem_en",   32'(mem_en),   32'(exp_if || exp_ld));
    chk("mem_we",   32'(mem_we),   32'(exp_ld && ld_we));
    sel_addr = exp_ld ? ld_addr : if_addr;
    wa       = sel_addr[12:2];
    chk("mem_addr", 32'(mem_addr), (exp_if || exp_ld) ? 32'(wa) : 32'h0);
    if (exp_ld && ld_we) chk("mem_wdata", mem_wdata, ld_wdata);

    e = '0;
    if (exp_if) begin
      e.kind = K_IF;
      e.data = ref_mem[wa];
    end else if (exp_ld && ld_we) begin
      ref_mem[wa] = ld_wdata;
      e.kind      = K_WR;
    end else if (exp_ld) begin
      e.kind = K_RD;
      e.data = ref_mem[wa];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    step(1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
    rst = 1'b1; if_ce = 1'b1; if_addr = 32'h0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h0;

    // Reset: everything forced low even with both requesters active.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0; if_ce = 1'b0;

    // Program download.
    ld_write(32'h0000_0000, 32'h3401_1100);
    ld_write(32'h0000_0004, 32'h3402_0020);
    ld_write(32'h0000_0008, 32'h3403_FF00);
    ld_write(32'h0000_1FFC, 32'h0BAD_F00D);

    // Loader write then readback.
    ld_write(32'h0000_0010, 32'hDEAD_BEEF);
    ld_we = 1'b0;
    step(1'b0, 1'b1);
    ld_req = 1'b0;

    // Fetch only, then address alignment and wrap.
    if_ce = 1'b1;
    if_addr = 32'h0; step(1'b1, 1'b0);
    if_addr = 32'h4; step(1'b1, 1'b0);
    if_addr = 32'h8; step(1'b1, 1'b0);
    if_addr = 32'h0000_2003; step(1'b1, 1'b0);
    if_addr = 32'h0000_1FFC; step(1'b1, 1'b0);
    if_ce = 1'b0;
    step(1'b0, 1'b0);

    // Contention: LD x4 then IF, repeating.
    if_ce = 1'b1; if_addr = 32'h4;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
    for (int i = 0; i < 12; i++) step((i % 5) == 4, (i % 5) != 4);
    step(1'b0, 1'b1);

    // Reset in mid-burst clears the run and drops the pending ack.
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(i == 4, i != 4);

    // Reset right after a fetch grant discards the fetch response.
    ld_req = 1'b0; if_addr = 32'h8;
    step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0; if_ce = 1'b0;
    step(1'b0, 1'b0);

    // A cycle with if_ce low restarts the loader run.
    if_ce = 1'b1; if_addr = 32'h0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    if_ce = 1'b0;
    step(1'b0, 1'b1);
    if_ce = 1'b1;
    for (int i = 0; i < 5; i++) step(i == 4, i != 4);
    if_ce = 1'b0;

    // Write immediately followed by read of the same word.
    ld_write(32'h0000_0020, 32'h1234_5678);
    ld_we = 1'b0; ld_addr = 32'h0000_0020;
    step(1'b0, 1'b1);
    ld_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: the IF stage (pc_reg fetch) and the instruction loader/debug port (program download, readback).
- Sits between pc_reg/if_id and the instruction memory block.
- Issues at most one memory access per cycle, returns data one cycle later, and raises a fetch stall request toward ctrl whenever fetch is not granted.

Parameters:
- ADDR_W, 11, word-address bits driven to memory; byte address bits [ADDR_W+1:2] are used.
- DATA_W, 32, instruction/data width.
- LD_BURST_MAX, 4, max consecutive loader grants while fetch is pending (starvation guard), >=1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_ce  in  1  fetch request (ChipEnable = 1).
- if_addr  in  32  fetch byte address (PC).
- if_inst  out  DATA_W  fetched instruction, ZeroWord when if_valid = 0.
- if_valid  out  1  if_inst valid this cycle.
- if_stall_req  out  1  fetch requested but not granted this cycle (combinational).
- ld_req  in  1  loader request; held stable with ld_we/ld_addr/ld_wdata until ld_gnt.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  DATA_W  write data.
- ld_gnt  out  1  loader request accepted this cycle (combinational).
- ld_ack  out  1  loader access completed (cycle after ld_gnt).
- ld_rdata  out  DATA_W  read data when ld_ack and read; 0 otherwise.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.

Behaviour:
- Grant, evaluated combinationally each cycle:
  - ld_sel = ld_req && (!if_ce || ld_run < LD_BURST_MAX).
  - if_sel = if_ce && !ld_sel.
- ld_run counter (width clog2(LD_BURST_MAX)+1):
  - +1 on each ld_sel while if_ce = 1.
  - Cleared on if_sel, or on any cycle with if_ce = 0.
  - Saturates at LD_BURST_MAX.
  - When ld_run = LD_BURST_MAX and both requesters are pending, fetch gets exactly one grant, then the loader may resume.
- Memory drive:
  - mem_en = ld_sel || if_sel.
  - mem_we = ld_sel && ld_we.
  - mem_addr = selected address [ADDR_W+1:2]; addr[1:0] ignored; upper bits ignored, so addresses wrap.
  - mem_wdata = ld_wdata.
  - All memory outputs 0 when idle.
- Response state register rsp, values {RSP_NONE, RSP_IF, RSP_LD_RD, RSP_LD_WR}, loaded every cycle from the current grant.
  - RSP_IF: if_valid = 1, if_inst = mem_rdata.
  - RSP_LD_RD: ld_ack = 1, ld_rdata = mem_rdata.
  - RSP_LD_WR: ld_ack = 1, ld_rdata = 0.
  - Latency: exactly 1 cycle from grant to valid/ack. Back-to-back grants give one response per cycle.
- if_stall_req = if_ce && !if_sel. Deasserted when if_ce = 0.
- Write followed by a read of the same address on the next cycle returns the new data; the memory is required to be write-first or no-change-on-read-next-cycle.
- Reset:
  - rsp = RSP_NONE, ld_run = 0.
  - if_valid, ld_ack, if_inst, ld_rdata = 0.
  - Reset asserted during a pending response discards that response; no ack/valid is produced after reset.
  - Combinational outputs (grants, mem_*, if_stall_req) are forced to 0 while rst = 1.

Optional Feature:
- Macro IMEM_BOOT_HOLD_EN.
- Defined:
  - Adds input boot_done (1 bit) and a boot_ok flag register, cleared by reset and set on the first cycle boot_done = 1 (sticky).
  - While boot_ok = 0, if_sel is forced to 0, so if_stall_req = if_ce, and ld_run is held at 0, so the loader gets every cycle.
  - Fetch begins the cycle after boot_done is seen.
- Not defined: no boot_done port; fetch is eligible from the first cycle after reset.

Test Plan:
- Fetch only: if_ce = 1, if_addr = 0x0, 0x4, 0x8 on consecutive cycles, memory words 0x34011100, 0x34020020, 0x3403FF00 -> if_valid = 1 each cycle after issue with those values; if_stall_req = 0 throughout.
- Loader write/readback: ld_req, ld_we = 1, ld_addr = 0x10, ld_wdata = 0xDEADBEEF, then read 0x10 -> ld_gnt each cycle; ld_ack with ld_rdata = 0, then ld_ack with 0xDEADBEEF.
- Contention, LD_BURST_MAX = 4: if_ce and ld_req held high for 12 cycles -> grant pattern LD,LD,LD,LD,IF repeating; if_stall_req high on the LD cycles.
- Address wrap/alignment: fetch at 0x2003 with ADDR_W = 11 -> mem_addr = 0x000; fetch at 0x1FFC -> mem_addr = 0x7FF.
- Reset mid-access: fetch granted at cycle N, rst = 1 at cycle N+1 -> if_valid = 0 and if_inst = 0 at N+1 and N+2; ld_run = 0 afterwards.
- IMEM_BOOT_HOLD_EN: if_ce = 1 and boot_done = 0 for 5 cycles with loader writes -> no fetch grants, if_stall_req = 1; boot_done pulse at cycle 6 -> first fetch granted at cycle 7.
